// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the decode/compute stage and the RV32M
// multiply/divide sequencer.
interface mdu_sequencer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  ra;
    logic [XLEN-1:0]  rb;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, op, ra, rb, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, op, ra, rb, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on one shared adder.
// Define MDU_FAST_PATH_EN to let divide-by-zero and zero-operand multiplies skip CALC.
module mdu_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           busy,
    mdu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_nx;

    logic [4:0]       cnt;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  mag_a, mag_b, acc_hi, acc_lo;
    logic             neg_q, sign_a_q, b_zero_q;
    logic             resp_valid_q;
    logic [XLEN-1:0]  resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;

    logic             accept, a_signed, b_signed, sa, sb, fast;
    logic [XLEN-1:0]  ra_mag, rb_mag;

    assign bus.req_ready  = (state == IDLE) && !flush;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = resp_tag_q;

    assign accept   = bus.req_valid && bus.req_ready;
    assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign sa       = a_signed && bus.ra[XLEN-1];
    assign sb       = b_signed && bus.rb[XLEN-1];
    assign ra_mag   = sa ? (XLEN'(0) - bus.ra) : bus.ra;
    assign rb_mag   = sb ? (XLEN'(0) - bus.rb) : bus.rb;

`ifdef MDU_FAST_PATH_EN
    assign fast = bus.op[2] ? (bus.rb == '0) : ((bus.ra == '0) || (bus.rb == '0));
`else
    assign fast = 1'b0;
`endif

    // One adder: multiply adds the multiplicand into the high half; divide
    // trial-subtracts the divisor from the shifted partial remainder.
    logic [XLEN:0]   add_a, add_b;
    logic            add_sub;
    logic [XLEN+1:0] add_res;

    always_comb begin
        if (op_q[2]) begin
            add_a   = {acc_hi, acc_lo[XLEN-1]};
            add_b   = {1'b0, mag_b};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, acc_hi};
            add_b   = acc_lo[0] ? {1'b0, mag_a} : '0;
            add_sub = 1'b0;
        end
        add_res = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)}
                + {{(XLEN+1){1'b0}}, add_sub};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, result;

    always_comb begin
        prod_fix = neg_q ? ((2*XLEN)'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
        quo_fix  = (neg_q && !b_zero_q) ? (XLEN'(0) - acc_lo) : acc_lo;
        rem_fix  = sign_a_q ? (XLEN'(0) - acc_hi) : acc_hi;
        case (op_q)
            3'd0:             result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result = quo_fix;
            default:          result = rem_fix;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = fast ? FIXUP : CALC;
                CALC:    if (cnt == 5'd31) state_nx = FIXUP;
                FIXUP:   state_nx = DONE;
                DONE:    if (resp_valid_q && bus.resp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state        <= state_nx;
            busy         <= (state_nx != IDLE);
            resp_valid_q <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            neg_q       <= 1'b0;
            sign_a_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= bus.op;
                    tag_q    <= bus.req_tag;
                    mag_a    <= ra_mag;
                    mag_b    <= rb_mag;
                    neg_q    <= sa ^ sb;
                    sign_a_q <= sa;
                    b_zero_q <= (bus.rb == '0);
                    cnt      <= '0;
                    // Fast path preloads the final accumulators: all-ones quotient with
                    // the dividend as remainder, or a zero product.
                    if (fast) begin
                        acc_hi <= bus.op[2] ? ra_mag : '0;
                        acc_lo <= bus.op[2] ? '1 : '0;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= bus.op[2] ? ra_mag : rb_mag;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_q[2]) begin
                        acc_hi <= add_res[XLEN+1] ? add_res[XLEN-1:0] : add_a[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], add_res[XLEN+1]};
                    end else begin
                        acc_hi <= add_res[XLEN:1];
                        acc_lo <= {add_res[0], acc_lo[XLEN-1:1]};
                    end
                end
                FIXUP: begin
                    resp_data_q <= result;
                    resp_tag_q  <= tag_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencer FSM, sitting beside the compute stage ALU.
- Decode routes M-extension ops here and stalls the compute stage while busy is high.
- Uses one shared 32-bit add/subtract datapath, iterated 32 times: shift-add for multiply, restoring division for divide.
- Returns one 32-bit result per request with a tag, through a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- TAG_W, 5, width of the destination-register tag carried with each request

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low; clock clk
- flush  input  1  pipeline flush; kills any in-flight op
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; (state==IDLE) && !flush
- op  input  3  RV funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- ra  input  32  operand A (rs1)
- rb  input  32  operand B (rs2)
- req_tag  input  TAG_W  destination tag
- resp_valid  output  1  result valid, held until accepted
- resp_ready  input  1  consumer accepts result
- resp_data  output  32  result
- resp_tag  output  TAG_W  tag of result
- busy  output  1  high in any state except IDLE; drives compute-stage stall

Behaviour:
- States: IDLE, CALC, FIXUP, DONE. All state and outputs are registered.
- Reset (rst_n=0 at posedge): state=IDLE, resp_valid=0, resp_data=0, resp_tag=0, busy=0, iteration counter=0. Reset mid-operation abandons the op with no response.
- IDLE:
  - Accept when req_valid && req_ready.
  - On accept, latch op and tag; latch operand magnitudes and signs (ra signed for MULH/MULHSU/DIV/REM; rb signed for MULH/DIV/REM; otherwise unsigned, sign=0).
  - Set cnt=0 and go to CALC.
- CALC, one iteration per cycle:
  - MUL*: shift-add on magnitudes into a 64-bit product register.
  - DIV*/REM*: restoring step; quotient bit = no borrow.
  - cnt increments each cycle; at cnt==31 the state moves to FIXUP. CALC lasts exactly 32 cycles.
- FIXUP, one cycle:
  - Product: negate the 64-bit product if signA^signB. MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
  - Quotient: negate if signA^signB, except when rb==0.
  - Remainder: negate if signA.
  - Go to DONE with resp_valid=1.
- DONE:
  - resp_valid, resp_data and resp_tag stay stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE with resp_valid=0.
  - No new request is accepted in the same cycle (req_ready is 0 outside IDLE).
- Latency: accept edge = cycle 0; resp_valid is first high in cycle 34. Throughput is one op per 35 cycles with resp_ready tied high.
- Division by zero: quotient 0xFFFFFFFF (DIV and DIVU), remainder = ra. This falls out of restoring division with the sign suppression above; no trap.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of magnitude arithmetic; no trap.
- flush (synchronous, any state): next state is IDLE, resp_valid=0, the in-flight result is discarded, and req_ready=0 that cycle.
- flush asserted together with req_valid in IDLE: flush wins and nothing is accepted.
- flush asserted together with resp_ready in DONE: the handshake is not counted as accepted, so the consumer must also squash.
- Operands are sampled only at the accept edge; ra and rb may change afterwards.

Optional Feature:
- Macro: MDU_FAST_PATH_EN.
- Defined, divide: rb==0 skips CALC. The accept edge loads the final quotient/remainder registers and goes directly to FIXUP, so resp_valid is high in cycle 2.
- Defined, multiply: ra==0 or rb==0 also takes the fast path, with result 0 in cycle 2.
- Not defined: every op takes the full 32-cycle CALC, and latency is always 34.
- Results are identical with and without the macro.

Test Plan:
- Reset mid-CALC: assert rst_n=0 for one cycle after accepting MUL 5*6 → resp_valid never rises; busy=0, req_ready=1 the next cycle.
- MUL ra=7, rb=0xFFFFFFFD (−3) → resp_data=0xFFFFFFEB, resp_tag echoed, resp_valid first high exactly 34 cycles after accept. MULH 0x80000000*0x80000000 → 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234; DIV −5/0 → 0xFFFFFFFF.
- Hold resp_ready=0 for 10 cycles in DONE → resp_data/resp_tag stable, busy=1, req_ready=0. Raise resp_ready → IDLE the next cycle; a queued request is accepted the cycle after.
- Assert flush at CALC cnt=15 → no response; IDLE next cycle. Then flush+req_valid in the same cycle → not accepted; the following request completes normally with the correct result. With MDU_FAST_PATH_EN defined, DIVU x/0 → resp_valid in cycle 2.
